// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing sets, colour-bar indices and width helper for the VGA timing block
package vga_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480  = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam vga_timing_t SVGA_800x600 = '{800, 40, 128, 88, 600, 1, 4, 23};

    // Colour index bits: [2]=green, [1]=red, [0]=blue
    typedef enum logic [2:0] {
        BAR_BLACK   = 3'd0,
        BAR_BLUE    = 3'd1,
        BAR_RED     = 3'd2,
        BAR_MAGENTA = 3'd3,
        BAR_GREEN   = 3'd4,
        BAR_CYAN    = 3'd5,
        BAR_YELLOW  = 3'd6,
        BAR_WHITE   = 3'd7
    } bar_colour_t;

    function automatic int clog2(input int unsigned n);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// rtl/vga_sync_counter.sv - h/v raster counters with active, sync window and colour-bar decode
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_640x480.h_active,
    parameter int H_FP     = VGA_640x480.h_fp,
    parameter int H_SYNC   = VGA_640x480.h_sync,
    parameter int H_BP     = VGA_640x480.h_bp,
    parameter int V_ACTIVE = VGA_640x480.v_active,
    parameter int V_FP     = VGA_640x480.v_fp,
    parameter int V_SYNC   = VGA_640x480.v_sync,
    parameter int V_BP     = VGA_640x480.v_bp,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = clog2(H_TOTAL),
    localparam int VW      = clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          active,
    output logic          hs_win,
    output logic          vs_win,
    output logic          first,
    output logic [2:0]    bar
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = clog2(BAR_W);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [BW-1:0] bar_cnt;

    // bar tracks h/BAR_W without a divider: pixel-in-bar counter rolls
    // into the bar index, which saturates at 7 through the blanking interval
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h       <= '0;
            v       <= '0;
            bar_cnt <= '0;
            bar     <= 3'd0;
        end else if (en) begin
            if (h == H_LAST) begin
                h       <= '0;
                bar_cnt <= '0;
                bar     <= 3'd0;
                v       <= (v == V_LAST) ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    if (bar != 3'd7) bar <= bar + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + BW'(1);
                end
            end
        end
    end

    assign active = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    assign hs_win = (h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC));
    // v only moves when h wraps, so VS edges land on line boundaries
    assign vs_win = (v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign first  = (h == '0) && (v == '0);

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA timing generator with pixel handshake, underflow flag and colour bars
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_640x480.h_active,
    parameter int H_FP     = VGA_640x480.h_fp,
    parameter int H_SYNC   = VGA_640x480.h_sync,
    parameter int H_BP     = VGA_640x480.h_bp,
    parameter int V_ACTIVE = VGA_640x480.v_active,
    parameter int V_FP     = VGA_640x480.v_fp,
    parameter int V_SYNC   = VGA_640x480.v_sync,
    parameter int V_BP     = VGA_640x480.v_bp,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int R_W      = 3,
    parameter int G_W      = 3,
    parameter int B_W      = 2,
    localparam int PIX_W   = R_W + G_W + B_W,
    localparam int X_W     = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int Y_W     = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic             CLKIN_IN,
    input  logic             RST_IN,
    input  logic             EN,
    input  logic             MODE,
    input  logic [PIX_W-1:0] PIX_DATA,
    input  logic             PIX_VALID,
    output logic             PIX_REQ,
    output logic [X_W-1:0]   PIX_X,
    output logic [Y_W-1:0]   PIX_Y,
    input  logic             UNDERFLOW_CLR,
    output logic             HS,
    output logic             VS,
    output logic             DE,
    output logic [R_W-1:0]   Red,
    output logic [G_W-1:0]   Green,
    output logic [B_W-1:0]   Blue,
    output logic             FRAME_START,
    output logic             UNDERFLOW
);

    logic        active;
    logic        hs_win;
    logic        vs_win;
    logic        first;
    logic [2:0]  bar;
    bar_colour_t cidx;
    logic        starve;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_counter (
        .clk    (CLKIN_IN),
        .rst    (RST_IN),
        .en     (EN),
        .h      (PIX_X),
        .v      (PIX_Y),
        .active (active),
        .hs_win (hs_win),
        .vs_win (vs_win),
        .first  (first),
        .bar    (bar)
    );

    assign PIX_REQ = EN && !MODE && active;
    assign starve  = PIX_REQ && !PIX_VALID;
    // Bars run white..black left to right, i.e. colour index counts down
    assign cidx    = bar_colour_t'(BAR_WHITE - bar);

    always_ff @(posedge CLKIN_IN or posedge RST_IN) begin
        if (RST_IN) begin
            HS          <= ~HS_POL;
            VS          <= ~VS_POL;
            DE          <= 1'b0;
            Red         <= '0;
            Green       <= '0;
            Blue        <= '0;
            FRAME_START <= 1'b0;
            UNDERFLOW   <= 1'b0;
        end else begin
            // A fresh starvation event outranks a simultaneous clear
            if (starve) UNDERFLOW <= 1'b1;
            else if (UNDERFLOW_CLR) UNDERFLOW <= 1'b0;

            if (EN) begin
                HS          <= hs_win ? HS_POL : ~HS_POL;
                VS          <= vs_win ? VS_POL : ~VS_POL;
                DE          <= active;
                FRAME_START <= first;
                if (!active) begin
                    Red   <= '0;
                    Green <= '0;
                    Blue  <= '0;
                end else if (MODE) begin
                    Red   <= {R_W{cidx[1]}};
                    Green <= {G_W{cidx[2]}};
                    Blue  <= {B_W{cidx[0]}};
                end else if (PIX_VALID) begin
                    Red   <= PIX_DATA[PIX_W-1 -: R_W];
                    Green <= PIX_DATA[B_W +: G_W];
                    Blue  <= PIX_DATA[B_W-1:0];
                end else begin
                    Red   <= '0;
                    Green <= '0;
                    Blue  <= '0;
                end
            end else begin
                // Syncs keep their level while paused; pixel outputs go dark
                DE          <= 1'b0;
                FRAME_START <= 1'b0;
                Red         <= '0;
                Green       <= '0;
                Blue        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - self-checking bench for vga_timing_ctrl
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       d_en, d_mode, d_valid, d_clr;
    logic [7:0] d_data;
    logic       d_req, d_hs, d_vs, d_de, d_fs, d_uf;
    logic [9:0] d_x, d_y;
    logic [2:0] d_r, d_g;
    logic [1:0] d_b;

    logic       s_en, s_mode, s_valid, s_clr;
    logic [7:0] s_data;
    logic       s_req, s_hs, s_vs, s_de, s_fs, s_uf;
    logic [4:0] s_x;
    logic [2:0] s_y;
    logic [2:0] s_r, s_g;
    logic [1:0] s_b;

    vga_timing_ctrl u_dut_vga (
        .CLKIN_IN(clk), .RST_IN(rst), .EN(d_en), .MODE(d_mode),
        .PIX_DATA(d_data), .PIX_VALID(d_valid), .PIX_REQ(d_req),
        .PIX_X(d_x), .PIX_Y(d_y), .UNDERFLOW_CLR(d_clr),
        .HS(d_hs), .VS(d_vs), .DE(d_de), .Red(d_r), .Green(d_g), .Blue(d_b),
        .FRAME_START(d_fs), .UNDERFLOW(d_uf)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut_small (
        .CLKIN_IN(clk), .RST_IN(rst), .EN(s_en), .MODE(s_mode),
        .PIX_DATA(s_data), .PIX_VALID(s_valid), .PIX_REQ(s_req),
        .PIX_X(s_x), .PIX_Y(s_y), .UNDERFLOW_CLR(s_clr),
        .HS(s_hs), .VS(s_vs), .DE(s_de), .Red(s_r), .Green(s_g), .Blue(s_b),
        .FRAME_START(s_fs), .UNDERFLOW(s_uf)
    );

    localparam int SH_A = 16, SH_FP = 2, SH_S = 3, SH_T = 23;
    localparam int SV_A = 4, SV_FP = 1, SV_S = 1, SV_T = 7;
    localparam int S_FRAME = SH_T * SV_T;

    int total = 0;
    int bad = 0;
    int d_n;
    int m_pos;
    logic       e_hs, e_vs, e_de, e_fs, e_uf;
    logic [7:0] e_rgb;
    logic [7:0] bars [8];

    typedef struct {
        bit         mode;
        logic [7:0] data;
        int         col;
        logic [7:0] rgb;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic d_tick();
        @(posedge clk);
        if (d_en) d_n++;
        #1;
    endtask

    task automatic d_goto(input int col);
        int k;
        for (k = 0; k < 1700; k++) begin
            if ((d_n % 800) == col && ((d_n / 800) % 525) < 480) break;
            d_tick();
        end
        chk("goto_timeout", 32'(k < 1700), 32'd1);
    endtask

    // Reference: raster position as a single frame-linear index
    task automatic s_model(input bit en, input bit mode, input bit valid,
                           input logic [7:0] data, input bit clr);
        int  h, v;
        bit  act;
        h   = m_pos % SH_T;
        v   = m_pos / SH_T;
        act = (h < SH_A) && (v < SV_A);
        if (en && !mode && act && !valid) e_uf = 1'b1;
        else if (clr) e_uf = 1'b0;
        if (en) begin
            e_hs = (h >= SH_A + SH_FP) && (h < SH_A + SH_FP + SH_S);
            e_vs = (v >= SV_A + SV_FP) && (v < SV_A + SV_FP + SV_S);
            e_de = act;
            e_fs = (m_pos == 0);
            if (!act) e_rgb = 8'h00;
            else if (mode) e_rgb = bars[h / (SH_A / 8)];
            else if (valid) e_rgb = data;
            else e_rgb = 8'h00;
            m_pos = (m_pos + 1) % S_FRAME;
        end else begin
            e_de  = 1'b0;
            e_fs  = 1'b0;
            e_rgb = 8'h00;
        end
    endtask

    task automatic s_cycle(input bit en, input bit mode, input bit valid,
                           input logic [7:0] data, input bit clr);
        @(negedge clk);
        s_en = en; s_mode = mode; s_valid = valid; s_data = data; s_clr = clr;
        #1;
        chk("s_req", 32'(s_req),
            32'(en && !mode && (m_pos % SH_T) < SH_A && (m_pos / SH_T) < SV_A));
        chk("s_x", 32'(s_x), 32'(m_pos % SH_T));
        chk("s_y", 32'(s_y), 32'(m_pos / SH_T));
        @(posedge clk);
        s_model(en, mode, valid, data, clr);
        #1;
        chk("s_out", 32'({s_hs, s_vs, s_de, s_r, s_g, s_b, s_fs, s_uf}),
            32'({e_hs, e_vs, e_de, e_rgb, e_fs, e_uf}));
    endtask

    initial begin
        int hs_low, de_cnt, vs_low, rgb_bad, hs_high, fs_cnt, diff;
        int falls[$];
        logic prev_hs;
        bit rmode, en_r;

        bars = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
        vecs[0]  = '{1'b1, 8'h00, 0,   8'hFF};
        vecs[1]  = '{1'b1, 8'h00, 80,  8'hFC};
        vecs[2]  = '{1'b1, 8'h00, 160, 8'h1F};
        vecs[3]  = '{1'b1, 8'h00, 560, 8'h00};
        vecs[4]  = '{1'b1, 8'hFF, 639, 8'h00};
        vecs[5]  = '{1'b1, 8'h00, 79,  8'hFF};
        vecs[6]  = '{1'b1, 8'h00, 400, 8'hE0};
        vecs[7]  = '{1'b0, 8'h05, 10,  8'h05};
        vecs[8]  = '{1'b0, 8'hE3, 639, 8'hE3};
        vecs[9]  = '{1'b0, 8'h5A, 0,   8'h5A};
        vecs[10] = '{1'b0, 8'hFF, 700, 8'h00};

        rst = 1'b1;
        d_en = 0; d_mode = 0; d_valid = 0; d_clr = 0; d_data = 8'h00;
        s_en = 0; s_mode = 0; s_valid = 0; s_clr = 0; s_data = 8'h00;
        hs_low = 0; de_cnt = 0; vs_low = 0; rgb_bad = 0; hs_high = 0; fs_cnt = 0;

        repeat (3) @(posedge clk);
        #3;
        chk("d_reset_out", 32'({d_hs, d_vs, d_de, d_r, d_g, d_b, d_fs, d_uf}), 32'h1800);
        chk("d_reset_xy", 32'({d_x, d_y}), 32'd0);
        chk("s_reset_out", 32'({s_hs, s_vs, s_de, s_r, s_g, s_b, s_fs, s_uf}), 32'h0);

        // Default geometry: first pixel request and frame start alignment
        rst = 1'b0;
        d_en = 1; d_valid = 1; d_data = 8'h05; d_n = 0;
        #1;
        chk("d_first_req", 32'({d_req, d_x, d_y}), 32'h100000);
        d_tick();
        chk("d_first_fs", 32'({d_fs, d_de, d_r, d_g, d_b}), 32'h305);
        d_tick();
        chk("d_fs_pulse_end", 32'(d_fs), 32'd0);

        prev_hs = d_hs;
        while (d_n < 1700) begin
            d_tick();
            if (prev_hs && !d_hs) falls.push_back(d_n);
            prev_hs = d_hs;
            if (d_n - 1 >= 800 && d_n - 1 < 1600) begin
                if (!d_hs) hs_low++;
                if (!d_vs) vs_low++;
                if (d_de) begin
                    de_cnt++;
                    if ({d_r, d_g, d_b} != 8'h05) rgb_bad++;
                end
            end
        end
        chk("d_hs_low_width", 32'(hs_low), 32'd96);
        chk("d_de_per_line", 32'(de_cnt), 32'd640);
        chk("d_vs_idle", 32'(vs_low), 32'd0);
        chk("d_rgb_data05", 32'(rgb_bad), 32'd0);
        diff = (falls.size() >= 2) ? falls[1] - falls[0] : -1;
        chk("d_hs_period", 32'(diff), 32'd800);

        for (int i = 0; i < 11; i++) begin
            d_mode = vecs[i].mode;
            d_data = vecs[i].data;
            d_valid = 1;
            d_goto(vecs[i].col);
            d_tick();
            chk($sformatf("d_vec%0d_rgb", i), 32'({d_r, d_g, d_b}), 32'(vecs[i].rgb));
        end
        chk("d_no_underflow", 32'(d_uf), 32'd0);

        // Underflow: set, sticky, clear, set-wins-over-clear
        d_mode = 0; d_data = 8'hFF;
        d_goto(5);
        d_valid = 0;
        d_tick();
        d_valid = 1;
        chk("d_uf_set", 32'({d_r, d_g, d_b, d_uf}), 32'h001);
        repeat (5) d_tick();
        chk("d_uf_sticky", 32'(d_uf), 32'd1);
        d_clr = 1;
        d_tick();
        d_clr = 0;
        chk("d_uf_clear", 32'(d_uf), 32'd0);
        d_goto(20);
        d_valid = 0; d_clr = 1;
        d_tick();
        d_valid = 1; d_clr = 0;
        chk("d_uf_set_wins", 32'({d_r, d_g, d_b, d_uf}), 32'h001);
        d_tick();
        chk("d_uf_after_tie", 32'(d_uf), 32'd1);

        // Asynchronous reset mid-line
        d_goto(300);
        #2;
        rst = 1'b1;
        #1;
        chk("d_async_reset_out", 32'({d_hs, d_vs, d_de, d_r, d_g, d_b, d_fs, d_uf}), 32'h1800);
        chk("d_async_reset_xy", 32'({d_x, d_y}), 32'd0);
        #297;
        rst = 1'b0;
        d_n = 0;
        #1;
        chk("d_rel_req", 32'({d_req, d_x, d_y}), 32'h100000);
        d_tick();
        chk("d_rel_fs", 32'({d_fs, d_de}), 32'h3);
        d_tick();
        chk("d_rel_fs_end", 32'(d_fs), 32'd0);
        d_en = 0;

        // Small geometry against the reference model
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("s_async_reset", 32'({s_hs, s_vs, s_de, s_fs, s_uf, s_x, s_y}), 32'd0);
        #10;
        rst = 1'b0;
        m_pos = 0;
        e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_uf = 0; e_rgb = 8'h00;

        rmode = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) rmode = !rmode;
            en_r = ($urandom_range(0, 7) != 0);
            if (i >= 1000 && i < 1010) en_r = 0;
            s_cycle(en_r, rmode, ($urandom_range(0, 15) != 0), 8'($urandom),
                    ($urandom_range(0, 7) == 0));
        end

        for (int i = 0; i < 2 * S_FRAME; i++) begin
            s_cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b1);
            if (s_hs) hs_high++;
            if (s_fs) fs_cnt++;
        end
        chk("s_hs_high_per_14_lines", 32'(hs_high), 32'd42);
        chk("s_fs_per_2_frames", 32'(fs_cnt), 32'd2);

        for (int i = 0; i < 10; i++) s_cycle(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
        chk("s_paused_de", 32'({s_de, s_r, s_g, s_b}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Parametrised successor of the fixed 640x480 RGB332 VGA controller. It generates HS, VS and DE from configurable horizontal and vertical timing, and requests pixels through a PIX_REQ/PIX_VALID handshake with sticky underflow detection. It has a built-in colour-bar test mode and configurable channel widths and sync polarity. It sits between the frame source (memory or pattern logic) and the DAC/pin outputs, clocked at the pixel rate.

Parameters:
H_ACTIVE, 640, visible pixels per line (multiple of 8)
H_FP, 16, horizontal front porch, clocks
H_SYNC, 96, horizontal sync width, clocks
H_BP, 48, horizontal back porch, clocks
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vertical sync width, lines
V_BP, 33, vertical back porch, lines
HS_POL, 0, HS active level (0 = active low)
VS_POL, 0, VS active level
R_W, 3, red width; G_W, 3, green width; B_W, 2, blue width (PIX_W = R_W+G_W+B_W)

Ports:
CLKIN_IN  in  1  pixel clock
RST_IN  in  1  asynchronous, active-high reset
EN  in  1  count enable
MODE  in  1  0 = external pixels, 1 = colour bars
PIX_DATA  in  PIX_W  packed {R,G,B}, R in MSBs
PIX_VALID  in  1  PIX_DATA valid this cycle
PIX_REQ  out  1  pixel at PIX_X/PIX_Y consumed this cycle
PIX_X  out  clog2(H_TOTAL)  current column
PIX_Y  out  clog2(V_TOTAL)  current line
UNDERFLOW_CLR  in  1  clears UNDERFLOW
HS, VS  out  1 each  syncs, polarity per HS_POL/VS_POL
DE  out  1  display enable
Red/Green/Blue  out  R_W/G_W/B_W  colour
FRAME_START  out  1  one-cycle pulse with output pixel (0,0)
UNDERFLOW  out  1  sticky starvation flag

Behaviour:
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
- h counts 0..H_TOTAL-1 on EN. At wrap, h returns to 0 and v increments. v wraps to 0 after V_TOTAL-1.
- EN=0: h and v hold; PIX_REQ=0; DE/RGB/FRAME_START driven 0 next cycle; HS/VS hold.
- PIX_X=h, PIX_Y=v, decoded from the counter registers.
- PIX_REQ = EN && MODE==0 && h<H_ACTIVE && v<V_ACTIVE.
- Sync windows: h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). VS changes at line boundaries (h=0).
- Output stage is one registered cycle. HS, VS, DE, RGB and FRAME_START all reflect the counter values of the previous cycle, so they stay mutually aligned. Latency from PIX_REQ to RGB is 1 clock.
- MODE 0: if PIX_REQ && PIX_VALID, RGB gets the PIX_DATA fields. If PIX_REQ && !PIX_VALID, RGB=0 for that pixel and UNDERFLOW=1 next cycle. PIX_DATA is ignored outside PIX_REQ.
- MODE 1: bar k = h/(H_ACTIVE/8), built from a pixel-in-bar counter with no divider. Colour index c = 7-k. Red = all ones if c[1], Green = all ones if c[2], Blue = all ones if c[0]. This gives white, yellow, cyan, green, magenta, red, blue, black. PIX_VALID is ignored and UNDERFLOW is never set.
- MODE changes take effect on the next pixel; no resync.
- Outside the active region: DE=0, RGB=0.
- UNDERFLOW is sticky until UNDERFLOW_CLR. If set and clear occur in the same cycle, set wins.
- Reset (asynchronous, any time, including mid-line): h=v=0, DE=0, RGB=0, FRAME_START=0, UNDERFLOW=0, HS=!HS_POL, VS=!VS_POL. PIX_REQ for (0,0) asserts in the first cycle with EN=1 after release.

Decomposition:
- Package vga_pkg holds:
  - timing constant sets VGA_640x480 and SVGA_800x600;
  - colour-bar index constants;
  - a clog2 function.
- Sub-module vga_sync_counter holds the h/v counters, active and sync window decode, and bar counter. The top level holds the handshake, output registers and underflow logic.

Test Plan:
- Defaults, MODE=0, PIX_VALID=1, PIX_DATA=8'h05 -> during DE: Red=3'b000, Green=3'b001, Blue=2'b01. HS period 800 clocks, low 96. VS period 420000 clocks, low 1600. DE high 640 per active line.
- PIX_VALID=0 for one active pixel -> RGB=0 one cycle later and UNDERFLOW=1. It stays 1 until an UNDERFLOW_CLR pulse. Set and clear in the same cycle -> stays 1.
- MODE=1 -> RGB=111/111/11 at h=0, yellow (111/111/00) at h=80, cyan at h=160, black at h=560..639. UNDERFLOW stays 0.
- Assert RST_IN for 300 ns mid-line -> all outputs take their reset values immediately. After release: PIX_X=0, PIX_Y=0, and FRAME_START pulses 1 clock after the first PIX_REQ.
- Small config (H 16/2/3/2, V 4/1/1/1, HS_POL=VS_POL=1) -> HS high for 3 clocks every 23. FRAME_START once per 161 clocks. EN held low for 10 cycles -> PIX_X/PIX_Y frozen and DE=0.
